interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Sequences the 6502 interrupt-entry microsequence (RESET, NMI, IRQ, BRK) on behalf of the CPU core once the interrupt controller has flagged a pending interrupt or a BRK opcode is decoded. It drives the bus through two dummy reads, three stack pushes (reads for RESET) and a two-byte vector fetch, then loads the new PC. It returns `int_clr`/`nmi_clr` to the interrupt controller and handles NMI hijack of IRQ/BRK.

## Interface
- No parameters.
- `clk_ph1`  in  1  single CPU clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request interrupt entry; sampled only in IDLE
- `brk`  in  1  qualifies `start` as a BRK opcode
- `nmi_pending`  in  1  NMI flag from interrupt controller
- `rdy`  in  1  bus ready; low stalls read states only
- `pc`  in  16  current program counter, latched on accept
- `p`  in  8  status register, latched on accept
- `sp`  in  8  current stack pointer (live)
- `data_in`  in  8  bus read data
- `addr`  out  16  bus address
- `data_out`  out  8  bus write data
- `rw`  out  1  1 = read, 0 = write
- `busy`  out  1  sequence in progress
- `sp_dec`  out  1  decrement SP this cycle
- `set_i`  out  1  set I flag
- `pc_load`  out  1  load `pc_new` into PC
- `pc_new`  out  16  `{data_in, vec_lo}`
- `int_clr`  out  1  clear perform-interrupt flag
- `nmi_clr`  out  1  clear NMI-pending flag
- `done`  out  1  last cycle of sequence

## Operation
- States: IDLE, DUMMY0, DUMMY1, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- The kind register takes RESET, NMI, IRQ or BRK. On accept, it is BRK if `brk`=1, else NMI if `nmi_pending`=1, else IRQ.
- IDLE: outputs inactive, `busy`=0. If `start`=1, latch `pc`→pc_l and `p`→p_l, set kind, and go to DUMMY0.
- DUMMY0: `addr`=pc_l, `rw`=1.
- DUMMY1: `addr`=pc_l+1 (16-bit wrap), `rw`=1.
- PUSH_PCH, PUSH_PCL, PUSH_P:
  - `addr`={8'h01, `sp`} and `sp_dec`=1.
  - `data_out` is pc_l[15:8], pc_l[7:0], then p_l|8'h20 with bit 4 = (kind==BRK).
  - `rw`=0, except `rw`=1 for RESET (dummy reads; SP still decrements).
- Vector select, registered on leaving PUSH_P:
  - RESET → FFFC.
  - NMI → FFFA.
  - IRQ/BRK → FFFA if `nmi_pending`=1 (hijack), else FFFE.
- `nmi_clr`=1 in PUSH_P when kind==NMI, or when kind is IRQ/BRK and `nmi_pending`=1. Never asserted for RESET.
- VEC_LO: `addr`=vector, `rw`=1, `set_i`=`rdy`. On advance, latch `data_in`→vec_lo.
- VEC_HI: `addr`=vector+1, `rw`=1. `pc_load`, `int_clr` and `done` each equal `rdy`. On advance, go to IDLE.
- Stall rule: read states (DUMMY0, DUMMY1, VEC_LO, VEC_HI) hold while `rdy`=0. Push states advance regardless of `rdy`.
- `start` while busy is ignored. `brk` is ignored unless `start`=1 in IDLE.

## Timing
- Reset (async, `rst`=0):
  - state=DUMMY0, kind=RESET, pc_l=0, p_l=0.
  - Outputs: `busy`=1, `rw`=1, `addr`=0000, `data_out`=00, all strobes 0.
  - The reset sequence starts on the first `clk_ph1` edge after `rst` rises.
- Asserting `rst` mid-sequence aborts immediately and restarts the RESET sequence; no partial `pc_load`.
- Outputs are Moore-decoded from state and registers, except `rdy` qualification of `set_i`, `pc_load`, `int_clr` and `done`.
- Latency, `rdy`=1 throughout: `start` sampled at edge N puts DUMMY0 in cycle N+1 and VEC_HI in cycle N+7. `pc_load`/`done` are high in cycle N+7; IDLE resumes in cycle N+8.
- Each `rdy`=0 cycle in a read state adds exactly one cycle. SP decrements exactly 3 times per sequence.
- SP wraps naturally (00→FF); the block never computes SP itself.

## Test plan
- Reset release, bus returns FC=34, FD=12 → `addr` sequence 0000, 0001, 01FD, 01FC, 01FB, FFFC, FFFD (with `sp`=FD stepped by bench). `rw`=1 every cycle. `pc_new`=1234 with `pc_load` in cycle 7. `nmi_clr` never asserted.
- IRQ: `pc`=C123, `p`=04, `sp`=FF, `start`=1, `brk`=0 → writes C1@01FF, 23@01FE, 24@01FD. Vector FFFE/FFFF. `int_clr`=1 only in cycle 7.
- BRK with `p`=00 → P push byte = 30. NMI with `p`=00 → P push byte = 20. NMI reads vector FFFA/FFFB with `nmi_clr` in PUSH_P.
- NMI hijack: IRQ started, `nmi_pending` rises during PUSH_PCL → `nmi_clr` in PUSH_P, vector FFFA. Pushed B bit stays 0 (IRQ) or 1 (BRK).
- `rdy`=0 for 2 cycles in DUMMY1 and 1 cycle in PUSH_PCH and VEC_HI → PUSH_PCH not stalled. Total sequence = 10 cycles. `pc_load` only once, when `rdy`=1.
- `rst` pulsed low during PUSH_PCL → immediate DUMMY0/RESET, `busy`=1, vector FFFC. `start` asserted while busy → no effect on sequence or latched PC.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// ============================================================================
// Module      : interrupt_sequencer
// Description : 6502 interrupt-entry microsequencer (RESET/NMI/IRQ/BRK):
//               two dummy reads, three stack pushes, two-byte vector fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module interrupt_sequencer (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        start,
    input  logic        brk,
    input  logic        nmi_pending,
    input  logic        rdy,
    input  logic [15:0] pc,
    input  logic [7:0]  p,
    input  logic [7:0]  sp,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        busy,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        int_clr,
    output logic        nmi_clr,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DUMMY0   = 3'd1,
        S_DUMMY1   = 3'd2,
        S_PUSH_PCH = 3'd3,
        S_PUSH_PCL = 3'd4,
        S_PUSH_P   = 3'd5,
        S_VEC_LO   = 3'd6,
        S_VEC_HI   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        K_RESET = 2'd0,
        K_NMI   = 2'd1,
        K_IRQ   = 2'd2,
        K_BRK   = 2'd3
    } kind_t;

    localparam logic [15:0] c_VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] c_VEC_RESET = 16'hFFFC;
    localparam logic [15:0] c_VEC_IRQ   = 16'hFFFE;
    localparam logic [7:0]  c_STACK_PG  = 8'h01;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [15:0] pc_l_q, pc_l_d;
    logic [7:0]  p_l_q, p_l_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  vec_lo_q, vec_lo_d;

    logic        w_take_nmi;
    logic        w_is_reset;
    logic [7:0]  w_status_push;

    // A pending NMI hijacks IRQ/BRK up to the moment the vector is chosen.
    assign w_take_nmi    = (kind_q == K_NMI) ||
                           (((kind_q == K_IRQ) || (kind_q == K_BRK)) && nmi_pending);
    assign w_is_reset    = (kind_q == K_RESET);
    assign w_status_push = ((p_l_q | 8'h20) & 8'hEF) |
                           {3'b000, (kind_q == K_BRK), 4'b0000};
    assign pc_new        = {data_in, vec_lo_q};

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state_q  <= S_DUMMY0;
            kind_q   <= K_RESET;
            pc_l_q   <= 16'h0000;
            p_l_q    <= 8'h00;
            vec_q    <= 16'h0000;
            vec_lo_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pc_l_q   <= pc_l_d;
            p_l_q    <= p_l_d;
            vec_q    <= vec_d;
            vec_lo_q <= vec_lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        pc_l_d   = pc_l_q;
        p_l_d    = p_l_q;
        vec_d    = vec_q;
        vec_lo_d = vec_lo_q;

        addr     = 16'h0000;
        data_out = 8'h00;
        rw       = 1'b1;
        busy     = 1'b1;
        sp_dec   = 1'b0;
        set_i    = 1'b0;
        pc_load  = 1'b0;
        int_clr  = 1'b0;
        nmi_clr  = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pc_l_d  = pc;
                    p_l_d   = p;
                    if (brk) begin
                        kind_d = K_BRK;
                    end else if (nmi_pending) begin
                        kind_d = K_NMI;
                    end else begin
                        kind_d = K_IRQ;
                    end
                    state_d = S_DUMMY0;
                end
            end

            S_DUMMY0: begin
                addr = pc_l_q;
                if (rdy) begin
                    state_d = S_DUMMY1;
                end
            end

            S_DUMMY1: begin
                addr = pc_l_q + 16'd1;
                if (rdy) begin
                    state_d = S_PUSH_PCH;
                end
            end

            // Push cycles never stall; RESET turns them into reads.
            S_PUSH_PCH: begin
                addr     = {c_STACK_PG, sp};
                sp_dec   = 1'b1;
                rw       = w_is_reset;
                data_out = pc_l_q[15:8];
                state_d  = S_PUSH_PCL;
            end

            S_PUSH_PCL: begin
                addr     = {c_STACK_PG, sp};
                sp_dec   = 1'b1;
                rw       = w_is_reset;
                data_out = pc_l_q[7:0];
                state_d  = S_PUSH_P;
            end

            S_PUSH_P: begin
                addr     = {c_STACK_PG, sp};
                sp_dec   = 1'b1;
                rw       = w_is_reset;
                data_out = w_status_push;
                nmi_clr  = w_take_nmi;
                if (w_is_reset) begin
                    vec_d = c_VEC_RESET;
                end else if (w_take_nmi) begin
                    vec_d = c_VEC_NMI;
                end else begin
                    vec_d = c_VEC_IRQ;
                end
                state_d = S_VEC_LO;
            end

            S_VEC_LO: begin
                addr  = vec_q;
                set_i = rdy;
                if (rdy) begin
                    vec_lo_d = data_in;
                    state_d  = S_VEC_HI;
                end
            end

            S_VEC_HI: begin
                addr    = vec_q + 16'd1;
                pc_load = rdy;
                int_clr = rdy;
                done    = rdy;
                if (rdy) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
// ============================================================================
// Module      : tb_interrupt_sequencer
// Description : Self-checking bench for interrupt_sequencer: directed literal
//               scenarios plus randomized traffic against a step-table model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_interrupt_sequencer;

    localparam int c_KR = 0;
    localparam int c_KN = 1;
    localparam int c_KI = 2;
    localparam int c_KB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        brk = 1'b0;
    logic        nmi_pending = 1'b0;
    logic        rdy = 1'b1;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  p = 8'h00;
    logic [7:0]  sp;
    logic [7:0]  data_in;
    logic [7:0]  rnd_data = 8'h00;
    logic        use_mem = 1'b1;
    logic        sp_set = 1'b0;
    logic [7:0]  sp_set_val = 8'h00;
    logic        chk_en = 1'b0;

    logic [15:0] addr;
    logic [15:0] pc_new;
    logic [7:0]  data_out;
    logic        rw, busy, sp_dec, set_i, pc_load, int_clr, nmi_clr, done;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_sequencer dut (
        .clk_ph1     (clk),
        .rst         (rst),
        .start       (start),
        .brk         (brk),
        .nmi_pending (nmi_pending),
        .rdy         (rdy),
        .pc          (pc),
        .p           (p),
        .sp          (sp),
        .data_in     (data_in),
        .addr        (addr),
        .data_out    (data_out),
        .rw          (rw),
        .busy        (busy),
        .sp_dec      (sp_dec),
        .set_i       (set_i),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .int_clr     (int_clr),
        .nmi_clr     (nmi_clr),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: mem_byte = 8'h11;
            16'hFFFB: mem_byte = 8'h22;
            16'hFFFC: mem_byte = 8'h34;
            16'hFFFD: mem_byte = 8'h12;
            16'hFFFE: mem_byte = 8'h00;
            16'hFFFF: mem_byte = 8'h80;
            default:  mem_byte = 8'hEA;
        endcase
    endfunction

    assign data_in = use_mem ? mem_byte(addr) : rnd_data;

    // CPU-side stack pointer: follows sp_dec, can be reloaded by the bench.
    always @(posedge clk) begin
        if (sp_set) sp <= sp_set_val;
        else if (sp_dec) sp <= sp - 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sequence = 7 bus steps; steps 1,2,6,7 are reads that wait for rdy.
    int          m_step;
    int          m_kind;
    logic [15:0] m_pc, m_vec;
    logic [7:0]  m_p, m_vlo;

    function automatic bit is_read_step(input int s);
        return (s == 1) || (s == 2) || (s == 6) || (s == 7);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_step <= 1;
            m_kind <= c_KR;
            m_pc   <= 16'h0000;
            m_p    <= 8'h00;
        end else if (m_step == 0) begin
            if (start) begin
                m_pc   <= pc;
                m_p    <= p;
                m_kind <= brk ? c_KB : (nmi_pending ? c_KN : c_KI);
                m_step <= 1;
            end
        end else begin
            if (m_step == 5)
                m_vec <= (m_kind == c_KR) ? 16'hFFFC :
                         ((m_kind == c_KN) || nmi_pending) ? 16'hFFFA : 16'hFFFE;
            if (m_step == 6 && rdy)
                m_vlo <= data_in;
            if (!is_read_step(m_step) || rdy)
                m_step <= (m_step == 7) ? 0 : m_step + 1;
        end
    end

    function automatic logic [15:0] m_addr();
        case (m_step)
            1:       return m_pc;
            2:       return m_pc + 16'd1;
            6:       return m_vec;
            7:       return m_vec + 16'd1;
            default: return {8'h01, sp};
        endcase
    endfunction

    function automatic logic [7:0] m_dout();
        case (m_step)
            3:       return m_pc[15:8];
            4:       return m_pc[7:0];
            default: return ((m_p | 8'h20) & 8'hEF) | ((m_kind == c_KB) ? 8'h10 : 8'h00);
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy",    busy,    m_step != 0);
            chk("m_sp_dec",  sp_dec,  m_step >= 3 && m_step <= 5);
            chk("m_set_i",   set_i,   m_step == 6 && rdy);
            chk("m_pc_load", pc_load, m_step == 7 && rdy);
            chk("m_int_clr", int_clr, m_step == 7 && rdy);
            chk("m_done",    done,    m_step == 7 && rdy);
            chk("m_nmi_clr", nmi_clr, m_step == 5 && m_kind != c_KR &&
                                      (m_kind == c_KN || nmi_pending));
            if (m_step != 0) begin
                chk("m_addr", addr, m_addr());
                chk("m_rw",   rw,   (m_step >= 3 && m_step <= 5) ? (m_kind == c_KR) : 1'b1);
            end
            if (m_step >= 3 && m_step <= 5)
                chk("m_data_out", data_out, m_dout());
            if (m_step == 7 && rdy)
                chk("m_pc_new", pc_new, {data_in, m_vlo});
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input string nm, input logic [15:0] pcv, input logic [7:0] pv,
                                input logic [7:0] spv, input logic brkv, input int nmi_at,
                                input logic [7:0] exp_pbyte, input logic [15:0] exp_vec,
                                input logic [15:0] exp_pcnew, input logic exp_nmiclr,
                                input logic busy_start);
        logic [15:0] ea;
        start = 1'b1; brk = brkv; pc = pcv; p = pv;
        sp_set = 1'b1; sp_set_val = spv; nmi_pending = (nmi_at == 0);
        @(negedge clk);
        chk({nm, "_idle_busy"}, busy, 1'b0);
        next_cycle();
        sp_set = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            start       = busy_start && (k <= 6);
            brk         = 1'b0;
            pc          = busy_start ? 16'h5555 : pcv;
            p           = busy_start ? 8'hFF : pv;
            nmi_pending = (k >= nmi_at);
            @(negedge clk);
            case (k)
                1:       ea = pcv;
                2:       ea = pcv + 16'd1;
                3:       ea = {8'h01, spv};
                4:       ea = {8'h01, spv - 8'd1};
                5:       ea = {8'h01, spv - 8'd2};
                6:       ea = exp_vec;
                default: ea = exp_vec + 16'd1;
            endcase
            chk({nm, "_addr"}, addr, ea);
            chk({nm, "_rw"}, rw, !(k >= 3 && k <= 5));
            if (k == 3) chk({nm, "_push_pch"}, data_out, pcv[15:8]);
            if (k == 4) chk({nm, "_push_pcl"}, data_out, pcv[7:0]);
            if (k == 5) chk({nm, "_push_p"}, data_out, exp_pbyte);
            chk({nm, "_nmi_clr"}, nmi_clr, (k == 5) && exp_nmiclr);
            chk({nm, "_int_clr"}, int_clr, k == 7);
            chk({nm, "_pc_load"}, pc_load, k == 7);
            if (k == 7) chk({nm, "_pc_new"}, pc_new, exp_pcnew);
            next_cycle();
        end
        start = 1'b0; nmi_pending = 1'b0;
        @(negedge clk);
        chk({nm, "_end_idle"}, busy, 1'b0);
        next_cycle();
    endtask

    logic [15:0] rst_addr [1:7];
    logic [15:0] stall_addr [1:10];
    logic        stall_rdy [1:10];
    int          pcl_count;

    initial begin
        rst_addr[1] = 16'h0000; rst_addr[2] = 16'h0001; rst_addr[3] = 16'h01FD;
        rst_addr[4] = 16'h01FC; rst_addr[5] = 16'h01FB; rst_addr[6] = 16'hFFFC;
        rst_addr[7] = 16'hFFFD;

        // Reset state, then the RESET sequence with sp=FD.
        rst = 1'b0; use_mem = 1'b1; sp_set = 1'b1; sp_set_val = 8'hFD;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        sp_set = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_rw", rw, 1'b1);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_strobes", {sp_dec, set_i, pc_load, int_clr, nmi_clr, done}, 6'b0);
        next_cycle();
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("reset_addr", addr, rst_addr[k]);
            chk("reset_rw", rw, 1'b1);
            chk("reset_nmi_clr", nmi_clr, 1'b0);
            chk("reset_pc_load", pc_load, k == 7);
            if (k == 7) chk("reset_pc_new", pc_new, 16'h1234);
            next_cycle();
        end
        @(negedge clk);
        chk("reset_end_idle", busy, 1'b0);
        next_cycle();

        run_directed("irq",     16'hC123, 8'h04, 8'hFF, 1'b0, 99, 8'h24, 16'hFFFE, 16'h8000, 1'b0, 1'b1);
        run_directed("brk",     16'h2000, 8'h00, 8'h80, 1'b1, 99, 8'h30, 16'hFFFE, 16'h8000, 1'b0, 1'b0);
        run_directed("nmi",     16'h3000, 8'h00, 8'h00, 1'b0, 0,  8'h20, 16'hFFFA, 16'h2211, 1'b1, 1'b0);
        run_directed("hij_irq", 16'h4000, 8'h00, 8'h40, 1'b0, 4,  8'h20, 16'hFFFA, 16'h2211, 1'b1, 1'b0);
        run_directed("hij_brk", 16'h4100, 8'h00, 8'h40, 1'b1, 4,  8'h30, 16'hFFFA, 16'h2211, 1'b1, 1'b0);

        // rdy stalls: 2 in DUMMY1, 1 in PUSH_PCH (no effect), 1 in VEC_HI.
        stall_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        stall_addr = '{16'h6000, 16'h6001, 16'h6001, 16'h6001, 16'h01FF,
                       16'h01FE, 16'h01FD, 16'hFFFE, 16'hFFFF, 16'hFFFF};
        start = 1'b1; brk = 1'b0; pc = 16'h6000; p = 8'h00; sp_set = 1'b1; sp_set_val = 8'hFF;
        next_cycle();
        start = 1'b0; sp_set = 1'b0; pcl_count = 0;
        for (int c = 1; c <= 10; c++) begin
            rdy = stall_rdy[c];
            @(negedge clk);
            chk("stall_busy", busy, 1'b1);
            chk("stall_addr", addr, stall_addr[c]);
            if (pc_load) pcl_count++;
            chk("stall_pc_load", pc_load, c == 10);
            next_cycle();
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_end_idle", busy, 1'b0);
        chk("stall_pc_load_once", pcl_count, 1);
        next_cycle();

        // Reset pulse during PUSH_PCL aborts into the RESET sequence.
        start = 1'b1; pc = 16'h7000; p = 8'h00; sp_set = 1'b1; sp_set_val = 8'hF0;
        next_cycle();
        start = 1'b0; sp_set = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b1);
        chk("abort_addr", addr, 16'h0000);
        chk("abort_rw", rw, 1'b1);
        chk("abort_pc_load", pc_load, 1'b0);
        next_cycle();
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("abort_seq_rw", rw, 1'b1);
            if (k == 6) chk("abort_vec", addr, 16'hFFFC);
            chk("abort_seq_pc_load", pc_load, k == 7);
            if (k == 7) chk("abort_pc_new", pc_new, 16'h1234);
            next_cycle();
        end

        // Randomized traffic checked by the model only.
        use_mem = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rnd_data    = 8'($urandom);
            rdy         = ($urandom % 4) != 0;
            start       = ($urandom % 3) == 0;
            brk         = ($urandom % 3) == 0;
            nmi_pending = ($urandom % 4) == 0;
            pc          = 16'($urandom);
            p           = 8'($urandom);
            sp_set      = ($urandom % 8) == 0;
            sp_set_val  = 8'($urandom);
            rst         = ($urandom % 250) != 0;
            next_cycle();
        end
        rst = 1'b1; start = 1'b0;
        repeat (20) next_cycle();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
